// File: rtl/serial_alu_pkg.sv
// Shared opcode encodings, FSM state type and sizing helpers for the digit-serial add/subtract unit.
package serial_alu_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A one-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_fs_digit.sv
// DIGIT-wide ripple of full-subtract cells; ADD reuses the subtractor by inverting b and the carry polarity.
module fs_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             op,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    always_comb begin
        logic [DIGIT-1:0] w_b_eff;
        logic [DIGIT:0]   w_br;
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        w_b_eff = (op == OP_ADD) ? ~b_d : b_d;
        w_br    = '0;
        d       = '0;
        w_br[0] = (op == OP_ADD) ? ~bin : bin;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]      = a_d[i] ^ w_b_eff[i] ^ w_br[i];
            w_br[i+1] = (~a_d[i] & w_b_eff[i]) | (~(a_d[i] ^ w_b_eff[i]) & w_br[i]);
        end
        // Borrow out of a - ~b - ~cin is the complement of the true carry out.
        bout = (op == OP_ADD) ? ~w_br[DIGIT] : w_br[DIGIT];
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/subtract with valid/ready handshakes, DIGIT bits per cycle.
// Defining SERIAL_ADDSUB_CMP_EN adds the lt_u / lt_s comparison outputs.
module serial_addsub
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             bout,
    output logic             ovf,
    output logic             zero
`ifdef SERIAL_ADDSUB_CMP_EN
    ,
    output logic             lt_u,
    output logic             lt_s
`endif
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_op;
    logic               r_cy;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_out_valid;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic [DIGIT-1:0]   w_d;
    logic               w_cy;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_ovf;

    fs_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d  (r_a[DIGIT-1:0]),
        .b_d  (r_b[DIGIT-1:0]),
        .op   (r_op),
        .bin  (r_cy),
        .d    (w_d),
        .bout (w_cy)
    );

    // Result fills from the MSB side so the last digit lands in the top bits.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign w_res_next = w_d;
    end else begin : g_multi_digit
        assign w_res_next = {w_d, r_res[WIDTH-1:DIGIT]};
    end

    assign w_ovf = (r_op == OP_ADD)
                 ? ((r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb))
                 : ((r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb));

`ifdef SERIAL_ADDSUB_CMP_EN
    logic r_lt_u;
    logic r_lt_s;
`endif

    // NOTE: all state, including the operand shift registers, is reset so a mid-run abort leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_op        <= OP_SUB;
            r_cy        <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_out_valid <= 1'b0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
`ifdef SERIAL_ADDSUB_CMP_EN
            r_lt_u      <= 1'b0;
            r_lt_s      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cy    <= bin;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_res <= w_res_next;
                    r_cy  <= w_cy;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_bout      <= w_cy;
                        r_ovf       <= w_ovf;
                        r_zero      <= ~|w_res_next;
`ifdef SERIAL_ADDSUB_CMP_EN
                        r_lt_u      <= (r_op == OP_SUB) && w_cy;
                        r_lt_s      <= (r_op == OP_SUB) && (w_res_next[WIDTH-1] ^ w_ovf);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
`ifdef SERIAL_ADDSUB_CMP_EN
    assign lt_u      = r_lt_u;
    assign lt_s      = r_lt_s;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: arithmetic reference model, per-cycle compare, directed vectors.
module tb_serial_addsub;
    import serial_alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             bout;
        logic             ovf;
        logic             zero;
        logic             lt_u;
        logic             lt_s;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             bout;
    logic             ovf;
    logic             zero;
    logic             lt_u;
    logic             lt_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_cur;
    logic exp_valid = 1'b0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
`ifdef SERIAL_ADDSUB_CMP_EN
        ,
        .lt_u      (lt_u),
        .lt_s      (lt_s)
`endif
    );

`ifndef SERIAL_ADDSUB_CMP_EN
    assign lt_u = 1'b0;
    assign lt_s = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow, true signed compare for lt_s.
    function automatic exp_t model(input logic o, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic c);
        exp_t   e;
        longint ux, uy, sx, sy, cin, u, s;
        ux  = longint'({32'd0, x});
        uy  = longint'({32'd0, y});
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        cin = longint'({63'd0, c});
        if (o == OP_ADD) begin
            u      = ux + uy + cin;
            s      = sx + sy + cin;
            e.bout = u[WIDTH];
            e.lt_u = 1'b0;
            e.lt_s = 1'b0;
        end else begin
            u      = ux - uy - cin;
            s      = sx - sy - cin;
            e.bout = (ux < uy + cin);
            e.lt_u = e.bout;
            e.lt_s = (s < 0);
        end
        e.res  = u[WIDTH-1:0];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.zero = (e.res == '0);
`ifndef SERIAL_ADDSUB_CMP_EN
        e.lt_u = 1'b0;
        e.lt_s = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [63:0] dut_bundle();
        return 64'({res, bout, ovf, zero, lt_u, lt_s});
    endfunction

    // Every cycle a result is presented it must match the model, which also proves it is held.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_valid) check("spurious_out_valid", 64'(out_valid), 64'(0));
            else            check("model_cmp", dut_bundle(), 64'(exp_cur));
        end
    end

    task automatic do_txn(input string name, input logic o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic c, input int hold,
                          input logic [WIDTH-1:0] e_res, input logic e_bout,
                          input logic e_ovf, input logic e_zero,
                          input logic e_lt_u, input logic e_lt_s);
        exp_t m;
        int   cyc;
        m = model(o, x, y, c);
        check({name, "_pin_model"}, 64'({m.res, m.bout, m.ovf, m.zero}),
              64'({e_res, e_bout, e_ovf, e_zero}));
        @(negedge clk);
        check({name, "_in_ready_idle"}, 64'(in_ready), 64'(1));
        exp_cur   = m;
        exp_valid = 1'b1;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        bin       = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = ~o;
        a        = $urandom();
        b        = $urandom();
        bin      = ~c;
        cyc      = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
            check({name, "_in_ready_run"}, 64'(in_ready), 64'(0));
        end
        check({name, "_latency"}, 64'(cyc), 64'(NDIG));
        check({name, "_literal"}, 64'({res, bout, ovf, zero}),
              64'({e_res, e_bout, e_ovf, e_zero}));
`ifdef SERIAL_ADDSUB_CMP_EN
        check({name, "_literal_lt"}, 64'({lt_u, lt_s}), 64'({e_lt_u, e_lt_s}));
`else
        if (e_lt_u || e_lt_s) begin
            check({name, "_lt_absent"}, 64'({lt_u, lt_s}), 64'(0));
        end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op       = ~op;
            a        = $urandom();
            b        = $urandom();
            @(posedge clk);
            #1;
            check({name, "_bp_in_ready"}, 64'(in_ready), 64'(0));
            check({name, "_bp_out_valid"}, 64'(out_valid), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        check({name, "_drop_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_in_ready_back"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = OP_SUB;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #12;
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_outputs", dut_bundle(), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_in_ready", 64'(in_ready), 64'(1));

        do_txn("sub_5_3",   OP_SUB, 32'd5, 32'd3, 1'b0, 0, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn("sub_3_5",   OP_SUB, 32'd3, 32'd5, 1'b0, 0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        do_txn("sub_min_1", OP_SUB, 32'h80000000, 32'd1, 1'b0, 0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_txn("add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_txn("add_negov", OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_txn("sub_bin",   OP_SUB, 32'h10, 32'h0F, 1'b1, 0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("add_cin",   OP_ADD, 32'h12345678, 32'h11111111, 1'b1, 0, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn("backpress", OP_SUB, 32'hDEADBEEF, 32'h12345678, 1'b0, 5, 32'hCC796877, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort a transaction in its fourth RUN cycle.
        @(negedge clk);
        in_valid = 1'b1;
        op       = OP_SUB;
        a        = 32'hFFFFFFFF;
        b        = 32'h0;
        bin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", dut_bundle(), 64'(0));
        check("midrun_reset_valid_ready", 64'({out_valid, in_ready}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrun_reset_idle", 64'(in_ready), 64'(1));
        do_txn("sub_10_10", OP_SUB, 32'd10, 32'd10, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle, digit-serial add/subtract unit for the ALU of the 5-stage pipeline.
- Generalises the 1-bit full-subtractor cell to WIDTH-bit operands, processing DIGIT bits per cycle.
- Returns result and flags through valid/ready handshakes.
- Used where area matters more than latency, e.g. the multi-cycle execute path.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIGIT, 4, bits processed per cycle; WIDTH % DIGIT must be 0.
- NDIG, WIDTH/DIGIT (localparam), number of RUN cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands.
- op  in  1  0 = SUB (a-b-bin), 1 = ADD (a+b+bin).
- a  in  WIDTH  minuend/augend.
- b  in  WIDTH  subtrahend/addend.
- bin  in  1  initial borrow (SUB) or carry (ADD).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- res  out  WIDTH  result.
- bout  out  1  final borrow (SUB) or carry-out (ADD).
- ovf  out  1  signed overflow.
- zero  out  1  res == 0.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low (rst_n); all state is cleared immediately on assertion.
- Reset values: state=IDLE; in_ready=0 while rst_n low, 1 in IDLE after release; out_valid, res, bout, ovf, zero = 0; digit counter = 0.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, op, bin, a[WIDTH-1], b[WIDTH-1]; counter=0; go to RUN.
- RUN: in_ready=0. Each cycle:
  - Feed the DIGIT LSBs of the a/b shift registers plus the running borrow/carry through the DIGIT-wide ripple cell.
  - Shift a and b right by DIGIT.
  - Shift the cell output into res from the MSB side.
  - Register the cell borrow/carry.
  - counter++.
  - When counter==NDIG-1, go to DONE on the next edge.
- DONE: out_valid=1; res, bout, ovf and zero are stable and held.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - in_valid is ignored while in DONE.
- Latency: out_valid rises exactly NDIG cycles after the accepting edge. Minimum initiation interval is NDIG+2 cycles with out_ready held high.
- Flags:
  - SUB: bout=1 iff unsigned a < b+bin; ovf = (a_msb != b_msb) && (res_msb != a_msb).
  - ADD: bout = carry-out; ovf = (a_msb == b_msb) && (res_msb != a_msb).
  - zero = ~|res.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Boundaries:
  - DIGIT==WIDTH: a single RUN cycle.
  - WIDTH % DIGIT != 0: elaboration-time error.
  - Inputs changing during RUN/DONE: no effect.
  - rst_n low at any state: immediate return to IDLE, partial result discarded.
  - Out-of-range op values cannot occur; op is 1 bit.

Optional Feature:
- Macro SERIAL_ADDSUB_CMP_EN.
- When defined, adds outputs lt_u (1 bit) and lt_s (1 bit), valid with out_valid, reset to 0.
  - lt_u = bout when op=SUB, else 0.
  - lt_s = res_msb ^ ovf when op=SUB, else 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package serial_alu_pkg:
  - OP_SUB=1'b0, OP_ADD=1'b1.
  - State enum state_e {IDLE, RUN, DONE}.
  - Function for NDIG derivation.
- Sub-module fs_digit (parameter DIGIT):
  - Combinational ripple of DIGIT full-subtract/add cells.
  - Inputs: a_d, b_d, op, bin. Outputs: d, bout.
  - ADD is implemented as subtraction of inverted b with inverted carry polarity.
- The top level holds the FSM, shift registers, counter and flag logic.

Test Plan (WIDTH=32, DIGIT=4, NDIG=8):
- SUB a=5, b=3, bin=0 -> res=2, bout=0, ovf=0, zero=0; out_valid exactly 8 cycles after accept.
- SUB a=3, b=5 -> res=0xFFFFFFFE, bout=1, ovf=0; with SERIAL_ADDSUB_CMP_EN: lt_u=1, lt_s=1.
- SUB a=0x80000000, b=1 -> res=0x7FFFFFFF, ovf=1, bout=0; lt_s=1 (CMP_EN).
- ADD a=0xFFFFFFFF, b=1, bin=0 -> res=0, bout=1, zero=1, ovf=0; ADD a=0x7FFFFFFF, b=1 -> ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored; after out_ready=1, in_ready returns within 1 cycle.
- Pull rst_n low in RUN cycle 4 -> outputs 0 immediately, state IDLE; the following SUB a=10, b=10 -> res=0, zero=1.
